// File: rtl/vu_level_meter_pkg.sv
// Shared types and helpers for the VU level meter: FSM encoding, magnitude width
// and the saturating absolute-value function applied to incoming samples.
package vu_level_meter_pkg;

    localparam int unsigned MAG_W   = 7;
    localparam int unsigned MAG_MAX = 127;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StHold  = 2'd1,
        StDecay = 2'd2
    } vu_state_e;

    // |b| of a two's-complement byte; -128 has no 7-bit magnitude and clamps to 127.
    function automatic logic [MAG_W-1:0] abs_sat8(input logic [7:0] b);
        logic [7:0] a;
        a = b[7] ? (~b + 8'd1) : b;
        return a[7] ? MAG_W'(MAG_MAX) : a[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/vu_level_meter_tick_gen.sv
// Reloadable down-counter: tick_o is high while the count sits at zero. Drives the
// decay prescaler of the level meter.
module vu_level_meter_tick_gen #(
    parameter int unsigned PERIOD = 500
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(PERIOD - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CntLoad;
        end else if (en_i) begin
            cnt_d = (cnt_q == '0) ? CntLoad : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/vu_level_meter.sv
// VU bar driver: tracks sample magnitude with peak-hold and linear decay, and shows it
// as a registered thermometer code plus a framing-error indicator.
module vu_level_meter
    import vu_level_meter_pkg::*;
#(
    parameter int unsigned LEDS         = 8,
    parameter int unsigned HOLD_CYCLES  = 5000,
    parameter int unsigned DECAY_PERIOD = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_in_i,
    input  logic             valid_i,
    input  logic             format_err_i,
    output logic [MAG_W-1:0] level_o,
    output logic [LEDS-1:0]  leds_o,
    output logic             err_led_o
);

    localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLD_CYCLES - 1);
    localparam int unsigned Step = 128 / LEDS;

    vu_state_e        state_q;
    logic [MAG_W-1:0] level_q;
    logic [HoldW-1:0] hold_cnt_q;
    logic             err_q;
    logic [LEDS-1:0]  leds_q;
    logic [LEDS-1:0]  leds_d;

    logic [MAG_W-1:0] mag;
    logic             accept;
    logic             capture;
    logic             pre_load;
    logic             pre_en;
    logic             decay_tick;

    // A zero sample never captures, so IDLE (level 0) shares the mag>=level rule.
    always_comb begin
        mag      = abs_sat8(data_in_i);
        accept   = valid_i & ~format_err_i;
        capture  = accept && (mag != '0) && (mag >= level_q);
        pre_load = (state_q == StHold) && (hold_cnt_q == '0) && !capture;
        pre_en   = (state_q == StDecay) && !capture;
    end

    vu_level_meter_tick_gen #(
        .PERIOD (DECAY_PERIOD)
    ) u_decay_tick (
        .clk    (clk),
        .rst    (rst),
        .load_i (pre_load),
        .en_i   (pre_en),
        .tick_o (decay_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            level_q    <= '0;
            hold_cnt_q <= '0;
        end else if (capture) begin
            state_q    <= StHold;
            level_q    <= mag;
            hold_cnt_q <= HoldLoad;
        end else begin
            case (state_q)
                StIdle: begin
                    level_q <= '0;
                end
                StHold: begin
                    if (hold_cnt_q == '0) begin
                        state_q <= StDecay;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 1'b1;
                    end
                end
                StDecay: begin
                    if (decay_tick) begin
                        if (level_q <= MAG_W'(1)) begin
                            level_q <= '0;
                            state_q <= StIdle;
                        end else begin
                            level_q <= level_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    level_q <= '0;
                end
            endcase
        end
    end

    // Framing error wins; any accepted sample (zero included) clears the indicator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (format_err_i) begin
            err_q <= 1'b1;
        end else if (accept) begin
            err_q <= 1'b0;
        end
    end

    for (genvar i = 0; i < LEDS; i++) begin : g_therm
        assign leds_d[i] = (level_q > MAG_W'(i * Step));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds_q <= '0;
        end else begin
            leds_q <= leds_d;
        end
    end

    assign level_o   = level_q;
    assign leds_o    = leds_q;
    assign err_led_o = err_q;

endmodule

// File: tb/tb_vu_level_meter.sv
// Directed plus random bench for vu_level_meter with two parameter sets sharing one
// stimulus stream, checked every cycle against a closed-form peak/decay model.
module tb_vu_level_meter;

    localparam int unsigned L0 = 8;
    localparam int unsigned H0 = 4;
    localparam int unsigned P0 = 2;
    localparam int unsigned L1 = 4;
    localparam int unsigned H1 = 1;
    localparam int unsigned P1 = 3;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       valid;
    logic       format_err;

    logic [6:0]    level0;
    logic [L0-1:0] leds0;
    logic          err0;
    logic [6:0]    level1;
    logic [L1-1:0] leds1;
    logic          err1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: level after a capture edge is peak, minus one per P cycles once H cycles pass.
    int         peak [2];
    int         kk   [2];
    int         hh   [2];
    int         pp   [2];
    int         nl   [2];
    logic [7:0] eleds[2];
    logic       eerr;

    vu_level_meter #(
        .LEDS         (L0),
        .HOLD_CYCLES  (H0),
        .DECAY_PERIOD (P0)
    ) dut0 (
        .clk          (clk),
        .rst          (rst),
        .data_in_i    (data_in),
        .valid_i      (valid),
        .format_err_i (format_err),
        .level_o      (level0),
        .leds_o       (leds0),
        .err_led_o    (err0)
    );

    vu_level_meter #(
        .LEDS         (L1),
        .HOLD_CYCLES  (H1),
        .DECAY_PERIOD (P1)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .data_in_i    (data_in),
        .valid_i      (valid),
        .format_err_i (format_err),
        .level_o      (level1),
        .leds_o       (leds1),
        .err_led_o    (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mlvl(input int j);
        int d;
        d = (kk[j] > hh[j]) ? (kk[j] - hh[j]) / pp[j] : 0;
        return (peak[j] > d) ? peak[j] - d : 0;
    endfunction

    function automatic int mmag(input logic [7:0] b);
        int v;
        v = b[7] ? int'(b) - 256 : int'(b);
        if (v < 0) v = -v;
        return (v > 127) ? 127 : v;
    endfunction

    function automatic logic [7:0] therm(input int lv, input int n);
        logic [7:0] t;
        t = 8'h00;
        for (int i = 0; i < n; i++) t[i] = (lv > i * (128 / n));
        return t;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            peak[j]  = 0;
            kk[j]    = 0;
            eleds[j] = 8'h00;
        end
        eerr = 1'b0;
    endtask

    task automatic model_step();
        int  cur;
        int  m;
        logic acc;
        acc = valid && !format_err;
        m   = mmag(data_in);
        for (int j = 0; j < 2; j++) begin
            cur      = mlvl(j);
            eleds[j] = therm(cur, nl[j]);
            if (acc && m > 0 && m >= cur) begin
                peak[j] = m;
                kk[j]   = 0;
            end else if (kk[j] < 100000) begin
                kk[j] = kk[j] + 1;
            end
        end
        if (format_err) eerr = 1'b1;
        else if (acc)   eerr = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("level0", 32'(level0), 32'(mlvl(0)));
        chk("leds0",  32'(leds0),  32'(eleds[0][L0-1:0]));
        chk("err0",   32'(err0),   32'(eerr));
        chk("level1", 32'(level1), 32'(mlvl(1)));
        chk("leds1",  32'(leds1),  32'(eleds[1][L1-1:0]));
        chk("err1",   32'(err1),   32'(eerr));
    endtask

    task automatic cycle(input logic v, input logic [7:0] d, input logic fe);
        valid      = v;
        data_in    = d;
        format_err = fe;
        @(posedge clk);
        cyc++;
        if (rst) model_step();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
    task automatic async_reset();
        valid      = 1'b0;
        format_err = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("rst_level0", 32'(level0), 32'd0);
        chk("rst_leds0",  32'(leds0),  32'd0);
        chk("rst_err0",   32'(err0),   32'd0);
        chk("rst_level1", 32'(level1), 32'd0);
        chk("rst_leds1",  32'(leds1),  32'd0);
        @(posedge clk);
        cyc++;
        #1;
        check_model();
        rst = 1'b1;
    endtask

    initial begin
        hh[0] = H0; pp[0] = P0; nl[0] = L0;
        hh[1] = H1; pp[1] = P1; nl[1] = L1;
        rst        = 1'b0;
        valid      = 1'b0;
        data_in    = 8'h00;
        format_err = 1'b0;
        model_reset();
        #1;
        chk("init_level0", 32'(level0), 32'd0);
        chk("init_leds0",  32'(leds0),  32'd0);
        chk("init_err0",   32'(err0),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // 1: +64 -> level 64, bar one cycle later
        cycle(1'b1, 8'h40, 1'b0);
        chk("t1_level", 32'(level0), 32'd64);
        chk("t1_leds_early", 32'(leds0), 32'h00);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t1_leds8", 32'(leds0), 32'h0F);
        chk("t1_leds4", 32'(leds1), 32'h3);

        // 2: -128 saturates; -64 from IDLE
        cycle(1'b1, 8'h80, 1'b0);
        chk("t2_level127", 32'(level0), 32'd127);
        cycle(1'b0, 8'h00, 1'b0);
        chk("t2_ledsFF", 32'(leds0), 32'hFF);
        async_reset();
        cycle(1'b1, 8'hC0, 1'b0);
        chk("t2_neg64", 32'(level0), 32'd64);

        // 3: peak 100, hold then decay to 0
        async_reset();
        cycle(1'b1, 8'd100, 1'b0);
        idle(H0);
        chk("t3_held", 32'(level0), 32'd100);
        idle(P0);
        chk("t3_first_drop", 32'(level0), 32'd99);
        idle(310);
        chk("t3_zero0", 32'(level0), 32'd0);
        chk("t3_zero1", 32'(level1), 32'd0);
        chk("t3_bar0",  32'(leds0),  32'd0);

        // 4: in DECAY at 50, mag 30 ignored, mag 50 restarts hold
        cycle(1'b1, 8'd51, 1'b0);
        idle(H0 + P0);
        chk("t4_at50", 32'(level0), 32'd50);
        cycle(1'b1, 8'd30, 1'b0);
        chk("t4_ignore30", 32'(level0), 32'd50);
        cycle(1'b1, 8'hCE, 1'b0);
        idle(H0 + P0 - 1);
        chk("t4_rehold", 32'(level0), 32'd50);
        idle(1);
        chk("t4_after_rehold", 32'(level0), 32'd49);

        // 5: framing-error window with a valid inside; zero sample clears err
        async_reset();
        for (int i = 0; i < 10; i++) cycle(i == 5, 8'h7F, 1'b1);
        chk("t5_err_set", 32'(err0), 32'd1);
        chk("t5_level",   32'(level0), 32'd0);
        idle(3);
        chk("t5_err_holds", 32'(err0), 32'd1);
        cycle(1'b1, 8'h00, 1'b0);
        chk("t5_err_clr", 32'(err0), 32'd0);
        chk("t5_zero_nocap", 32'(level0), 32'd0);

        // 6: reset mid-HOLD at 90, then normal capture
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'd90, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        async_reset();
        cycle(1'b1, 8'hA6, 1'b0);
        chk("t6_recap", 32'(level0), 32'd90);

        // Random traffic with occasional framing-error bursts
        for (int i = 0; i < 1500; i++) begin
            logic       v;
            logic       fe;
            logic [7:0] d;
            v  = ($urandom_range(0, 4) == 0);
            fe = ($urandom_range(0, 29) == 0);
            d  = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 3));
            cycle(v, d, fe);
            if (i == 700) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
